// File: rtl/aixh_mxc_cmd_loader_pkg.sv
//------------------------------------------------------------------------------
// Module      : aixh_mxc_cmd_loader_pkg
// Description : Shared MxConv command layout: word count, RawCommand0 fields,
//               packed CTRL_RawCommand record and the RawCommand0 sanity rule.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package aixh_mxc_cmd_loader_pkg;

    localparam int unsigned c_MXC_CMD_WORDS = 6;
    localparam int unsigned c_MXC_WORD_BITS = 64;

    typedef logic [c_MXC_WORD_BITS-1:0] raw_word_t;

    // RawCommand0: the two dimensions that must be non-zero for a usable command
    typedef struct packed {
        logic [31:0] reserved;
        logic [15:0] out_cwords;
        logic [15:0] filter_count;
    } raw_cmd0_t;

    // Word k sits at bits [64k+63:64k], so RawCommand0 is the least significant
    typedef struct packed {
        raw_word_t raw5;
        raw_word_t raw4;
        raw_word_t raw3;
        raw_word_t raw2;
        raw_word_t raw1;
        raw_cmd0_t raw0;
    } ctrl_raw_cmd_t;

    function automatic logic cmd0_sane(input raw_cmd0_t w);
        return (w.filter_count != '0) && (w.out_cwords != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aixh_mxc_cmd_loader.sv
//------------------------------------------------------------------------------
// Module      : aixh_mxc_cmd_loader
// Description : Assembles raw 64-bit command words into whole MxConv commands
//               held in a two-slot ping-pong buffer for the controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module aixh_mxc_cmd_loader
    import aixh_mxc_cmd_loader_pkg::*;
#(
    parameter int CMD_WORDS = c_MXC_CMD_WORDS,
    parameter int WORD_BITS = c_MXC_WORD_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_BITS-1:0]           in_data,
    input  logic                           in_last,
    input  logic                           abort,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [CMD_WORDS*WORD_BITS-1:0] cmd_data,
    output logic                           err_pulse,
    output logic                           busy
);

    localparam int                 c_CNT_W    = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(CMD_WORDS - 1);

    logic [WORD_BITS-1:0] r_slot [2][CMD_WORDS];
    logic [1:0]           r_full;
    logic                 r_wr_sel;
    logic                 r_rd_sel;
    logic [c_CNT_W-1:0]   r_wcnt;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_at_last;
    logic                 w_frame_err;
    logic                 w_complete;
    logic                 w_sane;
    logic                 w_commit;
    logic                 w_pop;
    logic [WORD_BITS-1:0] w_word0;
    logic [1:0]           w_full_nxt;

    // Ready comes from registered state only, never from in_valid
    assign in_ready    = ~r_full[r_wr_sel];
    assign w_accept    = in_valid & in_ready & ~abort;
    assign w_at_last   = (r_wcnt == c_LAST_IDX);
    assign w_frame_err = w_accept & (in_last ^ w_at_last);
    assign w_complete  = w_accept & in_last & w_at_last;

    // RawCommand0 is already stored unless the command is a single word long
    assign w_word0  = (r_wcnt == '0) ? in_data : r_slot[r_wr_sel][0];
    assign w_sane   = cmd0_sane(raw_cmd0_t'(64'(w_word0)));
    assign w_commit = w_complete & w_sane;
    assign w_pop    = cmd_valid & cmd_ready;

    // Commit and pop never target the same slot: commit needs it empty, pop full
    always_comb begin
        w_full_nxt = r_full;
        if (w_pop) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
        if (w_commit) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_full   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err  <= w_frame_err | (w_complete & ~w_sane);
            r_full <= w_full_nxt;
            if (abort || w_frame_err || w_complete) begin
                r_wcnt <= '0;
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_commit) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    // Payload storage carries no reset; validity lives entirely in r_full
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slot[r_wr_sel][r_wcnt] <= in_data;
        end
    end

    for (genvar k = 0; k < CMD_WORDS; k++) begin : g_word
        assign cmd_data[k*WORD_BITS +: WORD_BITS] = r_slot[r_rd_sel][k];
    end

    assign cmd_valid = r_full[r_rd_sel];
    assign err_pulse = r_err;
    assign busy      = (r_wcnt != '0) | (|r_full);

endmodule

`default_nettype wire

// File: tb/tb_aixh_mxc_cmd_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_aixh_mxc_cmd_loader
// Description : Self-checking bench for aixh_mxc_cmd_loader against a
//               queue-based reference model of the command buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_aixh_mxc_cmd_loader;
    import aixh_mxc_cmd_loader_pkg::*;

    localparam int c_W = 6;
    localparam int c_B = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             abort = 1'b0;
    logic             cmd_ready = 1'b0;
    logic [c_B-1:0]   in_data = '0;
    logic             in_ready;
    logic             cmd_valid;
    logic             err_pulse;
    logic             busy;
    logic [c_W*c_B-1:0] cmd_data;

    aixh_mxc_cmd_loader #(.CMD_WORDS(c_W), .WORD_BITS(c_B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .abort     (abort),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_B-1:0] data;
        bit             last;
        bit             abt;
    } offer_t;

    // Reference model: completed commands in delivery order plus the partial fill
    ctrl_raw_cmd_t  pend[$];
    logic [c_B-1:0] partial[$];
    bit             exp_err;
    offer_t         ofs[$];
    int             n_vec = 0;
    int             n_bad = 0;

    // mode 1: sane, 0: filter_count zero, 2: out_cwords zero
    function automatic logic [c_B-1:0] mk_word0(int mode);
        raw_cmd0_t w;
        w = raw_cmd0_t'({$urandom, $urandom});
        if (w.filter_count == '0) w.filter_count = 16'd1;
        if (w.out_cwords == '0)   w.out_cwords   = 16'd7;
        if (mode == 0) w.filter_count = '0;
        if (mode == 2) w.out_cwords   = '0;
        return w;
    endfunction

    function automatic void add_cmd(int mode, int nwords, int last_pos);
        offer_t o;
        for (int i = 0; i < nwords; i++) begin
            o.data = (i == 0) ? mk_word0(mode) : {$urandom, $urandom};
            o.last = (i == last_pos);
            o.abt  = 1'b0;
            ofs.push_back(o);
        end
    endfunction

    function automatic logic [3:0] exp_flags();
        return {pend.size() < 2, pend.size() > 0, exp_err, (partial.size() > 0) || (pend.size() > 0)};
    endfunction

    task automatic step(output bit acc);
        bit        pop_ok;
        raw_cmd0_t w0;
        acc    = !rst && in_valid && !abort && (pend.size() < 2);
        pop_ok = !rst && cmd_ready && (pend.size() > 0);
        @(posedge clk);
        exp_err = 1'b0;
        if (rst) begin
            pend.delete();
            partial.delete();
        end else begin
            if (pop_ok) void'(pend.pop_front());
            if (abort) begin
                partial.delete();
            end else if (acc) begin
                partial.push_back(in_data);
                if (in_last || partial.size() == c_W) begin
                    if (in_last && partial.size() == c_W) begin
                        w0 = partial[0];
                        if (w0.filter_count != '0 && w0.out_cwords != '0)
                            pend.push_back(ctrl_raw_cmd_t'({partial[5], partial[4], partial[3],
                                                            partial[2], partial[1], partial[0]}));
                        else
                            exp_err = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                    partial.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        step(acc);
        step(acc);
        n_vec++;
        if ({in_ready, cmd_valid, err_pulse, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset flags: got %b expected 1000", {in_ready, cmd_valid, err_pulse, busy});
        end
        rst = 1'b0;
        step(acc);
        n_vec++;
        if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
            n_bad++;
            $display("FAIL reset release flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
        end
    endtask

    task automatic test_single();
        bit acc;
        int budget = 100;
        cmd_ready = 1'b1;
        add_cmd(1, 6, 5);
        while ((ofs.size() > 0 || pend.size() > 0) && budget > 0) begin
            if (ofs.size() > 0) begin
                in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL single flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL single data: got %h expected %h", cmd_data, pend[0]);
                end
            end
            if (acc) void'(ofs.pop_front());
            budget--;
        end
        n_vec++;
        if (budget == 0) begin n_bad++; $display("FAIL single timeout: got budget 0 expected >0"); end
        ofs.delete();
    endtask

    task automatic test_back_to_back();
        bit acc;
        int budget = 200;
        int stall = 0;
        bit popped = 1'b0;
        add_cmd(1, 6, 5);
        add_cmd(1, 6, 5);
        add_cmd(1, 6, 5);
        while ((ofs.size() > 0 || pend.size() > 0) && budget > 0) begin
            if (ofs.size() > 0) begin
                in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last;
                cmd_ready = (stall == 3) && !popped;
            end else begin
                in_valid = 1'b0; in_last = 1'b0; cmd_ready = 1'b1;
            end
            if (cmd_ready && ofs.size() > 0) popped = 1'b1;
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL b2b flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL b2b data: got %h expected %h", cmd_data, pend[0]);
                end
            end
            if (acc) void'(ofs.pop_front());
            else if (ofs.size() > 0) stall++;
            budget--;
        end
        n_vec++;
        if (budget == 0) begin n_bad++; $display("FAIL b2b timeout: got budget 0 expected >0"); end
        ofs.delete();
    endtask

    task automatic test_errors();
        bit acc;
        int budget = 300;
        cmd_ready = 1'b1;
        add_cmd(1, 4, 3);
        add_cmd(1, 6, 5);
        add_cmd(1, 6, -1);
        add_cmd(0, 6, 5);
        add_cmd(2, 6, 5);
        add_cmd(1, 6, 5);
        while ((ofs.size() > 0 || pend.size() > 0) && budget > 0) begin
            if (ofs.size() > 0) begin
                in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL errors flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL errors data: got %h expected %h", cmd_data, pend[0]);
                end
            end
            if (acc) void'(ofs.pop_front());
            budget--;
        end
        n_vec++;
        if (budget == 0) begin n_bad++; $display("FAIL errors timeout: got budget 0 expected >0"); end
        ofs.delete();
    endtask

    task automatic test_abort();
        bit     acc;
        int     budget = 200;
        offer_t o;
        cmd_ready = 1'b0;
        add_cmd(1, 6, 5);
        add_cmd(1, 3, -1);
        o.data = {$urandom, $urandom}; o.last = 1'b0; o.abt = 1'b1;
        ofs.push_back(o);
        add_cmd(1, 6, 5);
        while ((ofs.size() > 0 || pend.size() > 0) && budget > 0) begin
            if (ofs.size() > 0) begin
                in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last; abort = ofs[0].abt;
            end else begin
                in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; cmd_ready = 1'b1;
            end
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL abort flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL abort data: got %h expected %h", cmd_data, pend[0]);
                end
            end
            if (acc || abort) void'(ofs.pop_front());
            budget--;
        end
        abort = 1'b0;
        n_vec++;
        if (budget == 0) begin n_bad++; $display("FAIL abort timeout: got budget 0 expected >0"); end
        ofs.delete();
    endtask

    task automatic test_reset_mid();
        bit acc;
        int budget = 100;
        cmd_ready = 1'b0;
        add_cmd(1, 6, 5);
        add_cmd(1, 5, -1);
        while (ofs.size() > 0 && budget > 0) begin
            in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last;
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL rstmid flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (acc) void'(ofs.pop_front());
            budget--;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready, cmd_valid, err_pulse, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rstmid async flags: got %b expected 1000", {in_ready, cmd_valid, err_pulse, busy});
        end
        step(acc);
        rst = 1'b0;
        ofs.delete();
        add_cmd(1, 6, 5);
        cmd_ready = 1'b1;
        budget = 100;
        while ((ofs.size() > 0 || pend.size() > 0) && budget > 0) begin
            if (ofs.size() > 0) begin
                in_valid = 1'b1; in_data = ofs[0].data; in_last = ofs[0].last;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL rstmid recover flags: got %b expected %b", {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL rstmid recover data: got %h expected %h", cmd_data, pend[0]);
                end
            end
            if (acc) void'(ofs.pop_front());
            budget--;
        end
        n_vec++;
        if (budget == 0) begin n_bad++; $display("FAIL rstmid timeout: got budget 0 expected >0"); end
        ofs.delete();
    endtask

    task automatic test_random();
        bit acc;
        int idx;
        for (int c = 0; c < 800; c++) begin
            if (c < 790) begin
                idx       = partial.size();
                in_valid  = ($urandom % 4) != 0;
                abort     = ($urandom % 40) == 0;
                cmd_ready = ($urandom % 3) != 0;
                in_data   = (idx == 0) ? mk_word0(($urandom % 8 == 0) ? 0 : 1) : {$urandom, $urandom};
                in_last   = (idx == c_W - 1) ^ (($urandom % 25) == 0);
            end else begin
                in_valid = 1'b0; abort = 1'b0; in_last = 1'b0; cmd_ready = 1'b1;
            end
            step(acc);
            n_vec++;
            if ({in_ready, cmd_valid, err_pulse, busy} !== exp_flags()) begin
                n_bad++;
                $display("FAIL random flags cyc %0d: got %b expected %b", c, {in_ready, cmd_valid, err_pulse, busy}, exp_flags());
            end
            if (pend.size() > 0) begin
                n_vec++;
                if (cmd_data !== pend[0]) begin
                    n_bad++;
                    $display("FAIL random data cyc %0d: got %h expected %h", c, cmd_data, pend[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_errors();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
